ffd_pipe: RTL and testbench

Parametrised successor to the single-bit `ffd` flip-flop. It is a WIDTH-bit, DEPTH-stage register pipeline with per-stage valid tracking, valid/ready back-pressure, bubble collapsing, synchronous flush and an occupancy count. It sits between any producer and consumer that need a fixed registered delay and must tolerate consumer stalls without dropping or duplicating data.

---
 rtl/ffd_pipe.sv | 89 ++++++++
 tb/tb_ffd_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ffd_pipe.sv
// ffd_pipe: WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits,
// valid/ready back-pressure, bubble collapsing, synchronous flush and an
// occupancy count. Data registers keep their contents when a stage is idle.
module ffd_pipe #(
   parameter int               WIDTH       = 8,
   parameter int               DEPTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                         aclk,
   input  logic                         srst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] up_v;
   logic [WIDTH-1:0] d    [DEPTH];
   logic [WIDTH-1:0] up_d [DEPTH];
   logic             chain;
   logic             in_xfer;
   logic             out_xfer;

   // Ready chain walks from the output back to the input so an empty stage
   // anywhere downstream lets everything above it move (bubble collapse).
   always_comb begin
      adv   = '0;
      chain = out_ready;
      for (int i = DEPTH-1; i >= 0; i--) begin
         adv[i] = !v[i] || chain;
         chain  = adv[i];
      end
   end

   assign in_ready  = adv[0] && !flush && !srst;
   assign in_xfer   = in_valid && in_ready;
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   assign out_xfer  = v[DEPTH-1] && out_ready;

   // Upstream source of each stage: the producer for stage 0, the previous
   // stage otherwise.
   always_comb begin
      up_v = '0;
      for (int i = 0; i < DEPTH; i++) begin
         up_d[i] = '0;
      end
      up_v[0] = in_xfer;
      up_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         up_v[i] = v[i-1];
         up_d[i] = d[i-1];
      end
   end

   // Stage registers and occupancy; reset beats flush, flush beats transfers
   // and leaves the data registers untouched.
   always_ff @(posedge aclk) begin
      if (srst) begin
         v     <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            d[i] <= RESET_VALUE;
         end
      end else if (flush) begin
         v     <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (adv[i]) begin
               v[i] <= up_v[i];
               if (up_v[i]) begin
                  d[i] <= up_d[i];
               end
            end
         end
         count <= count + CW'(in_xfer) - CW'(out_xfer);
      end
   end

endmodule

// File: tb/tb_ffd_pipe.sv
// tb_ffd_pipe: drives a DEPTH=4 and a DEPTH=1 instance with the same producer
// and consumer stimulus. Each instance has its own expected-word queue and
// occupancy model; a monitor per instance pops and compares on every output
// transfer.
module tb_ffd_pipe;

   localparam int W = 8;

   logic         aclk = 1'b0;
   logic         srst;
   logic         flush;
   logic         in_valid;
   logic         out_ready;
   logic [W-1:0] in_data;

   logic         in_ready_a, out_valid_a;
   logic [W-1:0] out_data_a;
   logic [2:0]   count_a;
   logic         in_ready_b, out_valid_b;
   logic [W-1:0] out_data_b;
   logic [0:0]   count_b;

   int           tests = 0;
   int           fails = 0;
   int           cyc   = 0;
   logic         armed = 1'b0;

   logic [W-1:0] q_a [$];
   logic [W-1:0] q_b [$];
   int           mc_a = 0, mc_b = 0;
   int           pops_a = 0, pops_b = 0;
   logic         inx_a = 1'b0, inx_b = 1'b0;
   logic         ox_a, ox_b;

   logic         watch = 1'b0;
   int           acc_a = -1, acc_b = -1;
   logic         seen_a = 1'b0, seen_b = 1'b0;

   logic [W-1:0] bp_words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

   always #5 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;

   ffd_pipe #(.WIDTH(W), .DEPTH(4), .RESET_VALUE(8'hA5)) dut_a (
      .aclk(aclk), .srst(srst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
      .count(count_a)
   );

   ffd_pipe #(.WIDTH(W), .DEPTH(1), .RESET_VALUE(8'hA5)) dut_b (
      .aclk(aclk), .srst(srst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
      .count(count_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A pipeline of depth dep holding mc words can take a new word when it has
   // a free slot anywhere or the consumer is taking the head word.
   function automatic logic exp_rdy(input int mc, input int dep);
      return (mc < dep || out_ready) && !flush && !srst;
   endfunction

   task automatic sample();
      logic ea, eb;
      #1;
      ea = exp_rdy(mc_a, 4);
      eb = exp_rdy(mc_b, 1);
      check("in_ready_a", in_ready_a, ea);
      check("in_ready_b", in_ready_b, eb);
      inx_a = in_valid && ea;
      inx_b = in_valid && eb;
      if (inx_a) q_a.push_back(in_data);
      if (inx_b) q_b.push_back(in_data);
      if (watch) begin
         if (!seen_a && acc_a >= 0 && out_valid_a && out_data_a == 8'h01) begin
            check("latency_a", cyc - acc_a, 4);
            seen_a = 1'b1;
         end
         if (!seen_b && acc_b >= 0 && out_valid_b && out_data_b == 8'h01) begin
            check("latency_b", cyc - acc_b, 1);
            seen_b = 1'b1;
         end
         if (inx_a && in_data == 8'h01 && acc_a < 0) acc_a = cyc;
         if (inx_b && in_data == 8'h01 && acc_b < 0) acc_b = cyc;
      end
   endtask

   task automatic run();
      sample();
      @(negedge aclk);
   endtask

   task automatic drain();
      int n;
      n         = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b0;
      srst      = 1'b0;
      while ((mc_a != 0 || mc_b != 0) && n < 40) begin
         run();
         n++;
      end
      check("drain_done", (mc_a == 0 && mc_b == 0), 1);
   endtask

   // Monitor for the DEPTH=4 instance.
   always @(negedge aclk) begin
      #2;
      if (armed) begin
         check("count_a", count_a, mc_a);
         if (mc_a == 0) check("empty_valid_a", out_valid_a, 0);
         if (mc_a == 4) check("full_valid_a", out_valid_a, 1);
         if (srst) begin
            q_a.delete();
            mc_a = 0;
         end else begin
            ox_a = out_valid_a && out_ready;
            if (ox_a) begin
               check("pop_nonempty_a", q_a.size() != 0, 1);
               if (q_a.size() != 0) begin
                  check("data_a", out_data_a, q_a.pop_front());
                  pops_a++;
               end
            end
            if (flush) begin
               q_a.delete();
               mc_a = 0;
            end else begin
               mc_a = mc_a + int'(inx_a) - int'(ox_a);
            end
         end
      end
   end

   // Monitor for the DEPTH=1 instance.
   always @(negedge aclk) begin
      #2;
      if (armed) begin
         check("count_b", count_b, mc_b);
         if (mc_b == 0) check("empty_valid_b", out_valid_b, 0);
         if (mc_b == 1) check("full_valid_b", out_valid_b, 1);
         if (srst) begin
            q_b.delete();
            mc_b = 0;
         end else begin
            ox_b = out_valid_b && out_ready;
            if (ox_b) begin
               check("pop_nonempty_b", q_b.size() != 0, 1);
               if (q_b.size() != 0) begin
                  check("data_b", out_data_b, q_b.pop_front());
                  pops_b++;
               end
            end
            if (flush) begin
               q_b.delete();
               mc_b = 0;
            end else begin
               mc_b = mc_b + int'(inx_b) - int'(ox_b);
            end
         end
      end
   end

   initial begin
      int n;
      int p;
      srst      = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // reset held for five edges
      repeat (5) @(posedge aclk);
      #1;
      check("rst_in_ready", in_ready_a, 0);
      check("rst_out_valid", out_valid_a, 0);
      check("rst_count", count_a, 0);
      check("rst_out_data", out_data_a, 8'hA5);
      @(negedge aclk);
      srst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready_a, 1);
      check("post_rst_out_data", out_data_a, 8'hA5);
      check("post_rst_out_valid", out_valid_a, 0);
      check("post_rst_in_ready_b", in_ready_b, 1);
      armed = 1'b1;
      @(negedge aclk);

      // streaming 0x01..0x10 with the consumer always ready
      watch     = 1'b1;
      out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1;
         in_data  = i[7:0];
         sample();
         if (i >= 6) begin
            check("stream_count_a", count_a, 4);
            check("stream_count_b", count_b, 1);
         end
         @(negedge aclk);
      end
      in_valid = 1'b0;
      n = 0;
      while (!(seen_a && seen_b) && n < 8) begin
         run();
         n++;
      end
      check("latency_seen", seen_a && seen_b, 1);
      watch = 1'b0;
      drain();

      // back-pressure fill
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = bp_words[i];
         run();
      end
      in_data = bp_words[4];
      for (int k = 0; k < 3; k++) begin
         sample();
         check("bp_in_ready", in_ready_a, 0);
         check("bp_count", count_a, 4);
         @(negedge aclk);
      end
      out_ready = 1'b1;
      sample();
      check("bp_full_ready", in_ready_a, 1);
      @(negedge aclk);
      drain();

      // bubble collapse
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hAA;
      run();
      in_valid = 1'b0;
      repeat (3) run();
      in_valid = 1'b1;
      in_data  = 8'hBB;
      sample();
      check("bubble_in_ready", in_ready_a, 1);
      @(negedge aclk);
      in_valid = 1'b0;
      sample();
      check("bubble_count", count_a, 2);
      @(negedge aclk);
      drain();

      // flush with three words resident
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'hC1 + 8'(i);
         run();
      end
      in_valid = 1'b0;
      n = 0;
      while (!out_valid_a && n < 10) begin
         run();
         n++;
      end
      check("flush_head_valid", out_valid_a, 1);
      p         = pops_a;
      flush     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h77;
      sample();
      check("flush_in_ready", in_ready_a, 0);
      @(negedge aclk);
      check("flush_head_taken", pops_a - p, 1);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sample();
      check("flush_out_valid", out_valid_a, 0);
      check("flush_count", count_a, 0);
      @(negedge aclk);

      // reset in the middle of a stream
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h60 + 8'(i);
         run();
      end
      srst = 1'b1;
      run();
      srst     = 1'b0;
      in_valid = 1'b0;
      sample();
      check("mrst_count_a", count_a, 0);
      check("mrst_valid_a", out_valid_a, 0);
      check("mrst_count_b", count_b, 0);
      check("mrst_valid_b", out_valid_b, 0);
      @(negedge aclk);

      // randomized traffic with occasional flush and reset
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = ((c % 600) < 300) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 63) == 0);
         srst      = ($urandom_range(0, 199) == 0);
         run();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
